// File: rtl/exec_core.sv
// Execution core: 512x16 code memory with registered read (IR), a
// FETCH/LOAD/EXEC microsequencer with HALT, and an 8-bit combinational ALU.
module exec_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        code_w_en,
    input  logic [8:0]  code_addr_in,
    input  logic [15:0] code_in,
    input  logic [8:0]  mem_addr,
    output logic [15:0] ir,
    input  logic [7:0]  alu_a,
    input  logic [7:0]  alu_b,
    output logic [7:0]  alu_out,
    output logic [7:0]  alu_flags,
    output logic [6:0]  signals,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_t;

    localparam int PC_INC     = 0;
    localparam int MAR_W_EN   = 1;
    localparam int REG_RW     = 2;
    localparam int ALU_OUT_EN = 3;
    localparam int FLAGS_EN   = 4;
    localparam int IMM_EN     = 5;
    localparam int FLAGS_W_EN = 6;

    logic [15:0] code_mem [0:511];
    logic [8:0]  eff_addr;
    logic        step_en;
    state_t      state_q;
    state_t      state_d;
    logic [6:0]  strobes;
    logic [4:0]  opcode;
    alu_op_t     alu_op;
    logic [8:0]  wide;
    logic [7:0]  result;
    logic        carry;
    logic        overflow;

    // The loader port takes priority over the datapath MAR
    assign eff_addr = code_w_en ? code_addr_in : mem_addr;

    always_ff @(posedge clk) begin
        if (code_w_en) begin
            code_mem[eff_addr] <= code_in;
        end
    end

    // Non-blocking read of the array gives the pre-write word on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else begin
            ir <= code_mem[eff_addr];
        end
    end

    assign step_en = run & ~code_w_en;
    assign opcode  = ir[15:11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        strobes = '0;
        case (state_q)
            FETCH: begin
                strobes[MAR_W_EN] = 1'b1;
                state_d           = LOAD;
            end
            LOAD: begin
                state_d = EXEC;
            end
            EXEC: begin
                strobes[PC_INC] = 1'b1;
                state_d         = FETCH;
                casez (opcode)
                    5'b00???: begin
                        strobes[ALU_OUT_EN] = 1'b1;
                        strobes[REG_RW]     = 1'b1;
                        strobes[FLAGS_W_EN] = 1'b1;
                    end
                    5'b01???: begin
                        strobes[FLAGS_W_EN] = 1'b1;
                    end
                    5'b10000: begin
                        strobes[IMM_EN] = 1'b1;
                        strobes[REG_RW] = 1'b1;
                    end
                    5'b10001: begin
                        strobes[FLAGS_EN] = 1'b1;
                        strobes[REG_RW]   = 1'b1;
                    end
                    5'b11111: begin
                        strobes = '0;
                        state_d = HALT;
                    end
                    default: begin
                    end
                endcase
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        if (!step_en) begin
            state_d = state_q;
        end
    end

    // Reset gating keeps strobes low the instant rst_n falls, even in FETCH
    assign signals = (rst_n && step_en) ? strobes : 7'd0;
    assign state   = state_q;

    assign alu_op = alu_op_t'(ir[13:11]);

    always_comb begin
        wide     = '0;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                wide     = {1'b0, alu_a} + {1'b0, alu_b};
                result   = wide[7:0];
                carry    = wide[8];
                overflow = (alu_a[7] == alu_b[7]) && (result[7] != alu_a[7]);
            end
            OP_SUB: begin
                wide     = {1'b0, alu_a} - {1'b0, alu_b};
                result   = wide[7:0];
                carry    = wide[8];
                overflow = (alu_a[7] != alu_b[7]) && (result[7] != alu_a[7]);
            end
            OP_AND: result = alu_a & alu_b;
            OP_OR:  result = alu_a | alu_b;
            OP_XOR: result = alu_a ^ alu_b;
            OP_NOT: result = ~alu_a;
            OP_SHL: begin
                result = {alu_a[6:0], 1'b0};
                carry  = alu_a[7];
            end
            OP_SHR: begin
                result = {1'b0, alu_a[7:1]};
                carry  = alu_a[0];
            end
            default: begin
            end
        endcase
    end

    assign alu_out   = result;
    assign alu_flags = {4'b0000, overflow, result[7], carry, (result == 8'd0)};

endmodule

// File: tb/tb_exec_core.sv
// Randomised bench for exec_core: an array/arithmetic reference model is
// compared every falling edge, plus directed literal checks on key scenarios.
module tb_exec_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        code_w_en;
    logic [8:0]  code_addr_in;
    logic [15:0] code_in;
    logic [8:0]  mem_addr;
    logic [15:0] ir;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic [7:0]  alu_flags;
    logic [6:0]  signals;
    logic [1:0]  state;

    logic        use_mar;
    logic [8:0]  addr_drv;
    logic [8:0]  pc;
    logic [8:0]  mar;
    logic        cmp_en;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [512];
    logic [15:0] m_ir;
    int          m_state;

    always #5 clk = ~clk;

    assign mem_addr = use_mar ? mar : addr_drv;

    exec_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .code_w_en    (code_w_en),
        .code_addr_in (code_addr_in),
        .code_in      (code_in),
        .mem_addr     (mem_addr),
        .ir           (ir),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .signals      (signals),
        .state        (state)
    );

    // Minimal datapath stand-in: MAR and PC react to the strobes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            mar <= '0;
        end else begin
            if (signals[1]) mar <= pc;
            if (signals[0]) pc  <= pc + 9'd1;
        end
    end

    function automatic int next_state(input int st, input logic [15:0] w);
        if (st == 0) return 1;
        if (st == 1) return 2;
        if (st == 2) return (w[15:11] == 5'd31) ? 3 : 0;
        return 3;
    endfunction

    function automatic logic [6:0] exp_signals(input int st, input logic [15:0] w,
                                               input logic rn, input logic rv,
                                               input logic wv);
        int op;
        op = int'(w[15:11]);
        if (!rn || !rv || wv) return 7'h00;
        if (st == 0) return 7'h02;
        if (st != 2) return 7'h00;
        if (op < 8)   return 7'h4D;
        if (op < 16)  return 7'h41;
        if (op == 16) return 7'h25;
        if (op == 17) return 7'h15;
        if (op == 31) return 7'h00;
        return 7'h01;
    endfunction

    // Returns {flags, result} from plain integer arithmetic
    function automatic logic [15:0] exp_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
        int ia, ib, sa, sb, r, s, c, v;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        c = 0;
        v = 0;
        case (op)
            3'd0: begin
                r = (ia + ib) % 256;
                c = (ia + ib > 255) ? 1 : 0;
                s = sa + sb;
                v = (s > 127 || s < -128) ? 1 : 0;
            end
            3'd1: begin
                r = (ia - ib + 256) % 256;
                c = (ia < ib) ? 1 : 0;
                s = sa - sb;
                v = (s > 127 || s < -128) ? 1 : 0;
            end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 255 - ia;
            3'd6: begin
                r = (ia * 2) % 256;
                c = (ia >= 128) ? 1 : 0;
            end
            default: begin
                r = ia / 2;
                c = ia % 2;
            end
        endcase
        return {4'h0, v[0], (r >= 128) ? 1'b1 : 1'b0, c[0], (r == 0) ? 1'b1 : 1'b0, r[7:0]};
    endfunction

    always @(posedge clk) begin
        if (code_w_en) m_mem[code_addr_in] <= code_in;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ir    <= '0;
            m_state <= 0;
        end else begin
            m_ir <= m_mem[code_w_en ? code_addr_in : mem_addr];
            if (run && !code_w_en) m_state <= next_state(m_state, m_ir);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] ea;
            ea = exp_alu(alu_a, alu_b, m_ir[13:11]);
            checkOutput("cmp_ir", ir, m_ir);
            checkOutput("cmp_state", state, m_state);
            checkOutput("cmp_signals", signals, exp_signals(m_state, m_ir, rst_n, run, code_w_en));
            checkOutput("cmp_alu_out", alu_out, ea[7:0]);
            checkOutput("cmp_alu_flags", alu_flags, ea[15:8]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [8:0] a, input logic [15:0] d);
        code_w_en    = 1'b1;
        code_addr_in = a;
        code_in      = d;
        step();
        code_w_en    = 1'b0;
    endtask

    task automatic expectCycle(input string name, input int st, input logic [6:0] sg);
        step();
        checkOutput({name, "_state"}, state, st);
        checkOutput({name, "_signals"}, signals, sg);
    endtask

    function automatic logic [15:0] random_word();
        logic [4:0] top;
        case ($urandom_range(0, 5))
            0: top = 5'($urandom_range(0, 7));
            1: top = 5'($urandom_range(8, 15));
            2: top = 5'd16;
            3: top = 5'd17;
            4: top = 5'd31;
            default: top = 5'($urandom_range(0, 31));
        endcase
        return {top, 11'($urandom)};
    endfunction

    task automatic applyStimulus();
        step();
        rst_n        = ($urandom_range(0, 199) == 0 || (m_state == 3 && $urandom_range(0, 9) == 0)) ? 1'b0 : 1'b1;
        run          = ($urandom_range(0, 9) != 0);
        code_w_en    = ($urandom_range(0, 19) == 0);
        code_addr_in = 9'($urandom_range(0, 47));
        code_in      = random_word();
        alu_a        = 8'($urandom);
        alu_b        = 8'($urandom);
        use_mar      = ($urandom_range(0, 15) != 0);
        addr_drv     = 9'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        rst_n = 1'b1; run = 1'b1; code_w_en = 1'b0; code_addr_in = '0; code_in = '0;
        use_mar = 1'b0; addr_drv = '0; alu_a = '0; alu_b = '0; cmp_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_ir", ir, 16'h0000);
        checkOutput("reset_state", state, 0);
        checkOutput("reset_signals", signals, 7'h00);
        step();
        run   = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 512; i++) writeWord(9'(i), 16'h0000);
        step();
        cmp_en = 1'b1;

        writeWord(9'd5, 16'h1234);
        writeWord(9'd511, 16'hABCD);
        addr_drv = 9'd511;
        step();
        checkOutput("load_511", ir, 16'hABCD);
        addr_drv = 9'd5;
        step();
        checkOutput("load_5", ir, 16'h1234);
        writeWord(9'd5, 16'h5555);
        checkOutput("read_before_write", ir, 16'h1234);

        writeWord(9'd10, 16'h0000);
        writeWord(9'd11, 16'h0800);
        writeWord(9'd12, 16'h3800);
        addr_drv = 9'd10;
        step();
        alu_a = 8'h7F; alu_b = 8'h01; #1;
        checkOutput("add_ovf_out", alu_out, 8'h80);
        checkOutput("add_ovf_flags", alu_flags, 8'h0C);
        alu_a = 8'hFF; alu_b = 8'h01; #1;
        checkOutput("add_carry_out", alu_out, 8'h00);
        checkOutput("add_carry_flags", alu_flags, 8'h03);
        addr_drv = 9'd11;
        step();
        alu_a = 8'h03; alu_b = 8'h05; #1;
        checkOutput("sub_out", alu_out, 8'hFE);
        checkOutput("sub_flags", alu_flags, 8'h06);
        addr_drv = 9'd12;
        step();
        alu_a = 8'h01; #1;
        checkOutput("shr_out", alu_out, 8'h00);
        checkOutput("shr_flags", alu_flags, 8'h03);

        writeWord(9'd0, 16'h0000);
        writeWord(9'd1, 16'h8000);
        writeWord(9'd2, 16'h8800);
        writeWord(9'd3, 16'h4000);
        writeWord(9'd4, 16'hF800);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; use_mar = 1'b1; run = 1'b1;
        #1;
        checkOutput("seq_fetch_signals", signals, 7'h02);
        expectCycle("add_load", 1, 7'h00);
        expectCycle("add_exec", 2, 7'h4D);
        checkOutput("add_exec_ir", ir, 16'h0000);
        expectCycle("movi_fetch", 0, 7'h02);
        expectCycle("movi_load", 1, 7'h00);
        run = 1'b0; #1;
        checkOutput("freeze_signals", signals, 7'h00);
        step();
        checkOutput("freeze_state", state, 1);
        run = 1'b1;
        expectCycle("movi_exec", 2, 7'h25);
        expectCycle("rdfl_fetch", 0, 7'h02);
        expectCycle("rdfl_load", 1, 7'h00);
        expectCycle("rdfl_exec", 2, 7'h15);
        expectCycle("cmp_fetch", 0, 7'h02);
        expectCycle("cmp_load", 1, 7'h00);
        expectCycle("cmp_exec", 2, 7'h41);
        expectCycle("halt_fetch", 0, 7'h02);
        expectCycle("halt_load", 1, 7'h00);
        expectCycle("halt_exec", 2, 7'h00);
        checkOutput("halt_exec_ir", ir, 16'hF800);
        for (int i = 0; i < 5; i++) expectCycle("halted", 3, 7'h00);
        rst_n = 1'b0; #1;
        checkOutput("halt_reset_state", state, 0);
        step();
        rst_n = 1'b1; #1;
        checkOutput("restart_signals", signals, 7'h02);
        expectCycle("restart_load", 1, 7'h00);
        expectCycle("restart_exec", 2, 7'h4D);
        rst_n = 1'b0; #1;
        checkOutput("async_reset_signals", signals, 7'h00);
        checkOutput("async_reset_state", state, 0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) applyStimulus();
        step();
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
